// File: rtl/cpu_fetch.sv
// Instruction fetch front end: 8-subcycle bus sequencer, program counter and opcode latch.
// Define CPU_FETCH_IO_EN to enable SRC/WRR bus cycles and the ROM/RAM command strobes.
module cpu_fetch (
   input  logic        clock,
   input  logic        reset,
   inout  wire  [3:0]  data,
   output logic        sync,
   output logic        cmd,
   input  logic        jump_valid,
   input  logic [11:0] jump_addr,
   input  logic [7:0]  src_addr,
   input  logic [3:0]  acc,
   output logic [3:0]  opr,
   output logic [3:0]  opa,
   output logic        inst_valid,
   output logic [11:0] fetch_addr
);

   typedef enum logic [2:0] {
      SubA1 = 3'd0, SubA2, SubA3, SubM1, SubM2, SubX1, SubX2, SubX3
   } sub_e;

   sub_e        sub_q, sub_d;
   logic [11:0] pc_q, pc_d;
   logic [11:0] fetch_addr_q, fetch_addr_d;
   logic [3:0]  opr_raw_q, opr_raw_d;
   logic [3:0]  opr_q, opr_d;
   logic [3:0]  opa_q, opa_d;
   logic [3:0]  bus_out;
   logic        bus_oe;

   // opr_raw_q holds the high nibble during M2 so the visible opcode changes atomically in X1.
   always_comb begin
      sub_d        = sub_e'(sub_q + 3'd1);
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      opr_raw_d    = opr_raw_q;
      opr_d        = opr_q;
      opa_d        = opa_q;
      case (sub_q)
         SubM1: opr_raw_d = data;
         SubM2: begin
            opr_d        = opr_raw_q;
            opa_d        = data;
            fetch_addr_d = pc_q;
         end
         SubX3: pc_d = jump_valid ? jump_addr : pc_q + 12'd1;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sub_q        <= SubA1;
         pc_q         <= 12'h000;
         fetch_addr_q <= 12'h000;
         opr_raw_q    <= 4'h0;
         opr_q        <= 4'h0;
         opa_q        <= 4'h0;
      end else begin
         sub_q        <= sub_d;
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         opr_raw_q    <= opr_raw_d;
         opr_q        <= opr_d;
         opa_q        <= opa_d;
      end
   end

`ifdef CPU_FETCH_IO_EN
   logic is_src;
   logic is_wrr;
   assign is_src = (opr_q == 4'h2) && opa_q[0];
   assign is_wrr = (opr_q == 4'hE) && (opa_q == 4'h2);
`else
   logic unused_io;
   assign unused_io = ^{src_addr, acc};
`endif

   // Bus drive and strobes are pure decodes of the counter; reset forces them idle immediately.
   always_comb begin
      bus_oe  = 1'b0;
      bus_out = 4'h0;
      cmd     = 1'b1;
      if (!reset) begin
         case (sub_q)
            SubA1: begin bus_oe = 1'b1; bus_out = pc_q[3:0];  end
            SubA2: begin bus_oe = 1'b1; bus_out = pc_q[7:4];  end
            SubA3: begin bus_oe = 1'b1; bus_out = pc_q[11:8]; end
`ifdef CPU_FETCH_IO_EN
            SubM2: cmd = (opr_raw_q != 4'hE);
            SubX2: begin
               if (is_src) begin
                  cmd     = 1'b0;
                  bus_oe  = 1'b1;
                  bus_out = src_addr[7:4];
               end else if (is_wrr) begin
                  bus_oe  = 1'b1;
                  bus_out = acc;
               end
            end
            SubX3: begin
               if (is_src) begin
                  bus_oe  = 1'b1;
                  bus_out = src_addr[3:0];
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign data       = bus_oe ? bus_out : 4'bzzzz;
   assign sync       = !reset && (sub_q == SubX3);
   assign inst_valid = !reset && (sub_q == SubX1);
   assign opr        = opr_q;
   assign opa        = opa_q;
   assign fetch_addr = fetch_addr_q;

endmodule
